// File: rtl/fir_pkg.sv
// Shared register map, ap_ctrl bit layout and run-sequencer states for the
// FIR control block.
package fir_pkg;

  localparam int ADDR_AP_CTRL  = 'h000;
  localparam int ADDR_DLEN     = 'h010;
  localparam int ADDR_TAP_BASE = 'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fir_state_e;

endpackage

// File: rtl/fir_axil_slave.sv
// AXI-Lite slave front end: accepts writes and reads, latches address/data and
// returns read data three cycles after the read address is presented.
module fir_axil_slave
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   wr_vld_p1,
  output logic [pADDR_WIDTH-1:0] wr_addr_p1,
  output logic [pDATA_WIDTH-1:0] wr_data_p1,
  output logic                   rd_vld_p1,
  output logic [pADDR_WIDTH-1:0] rd_addr_p1,
  input  logic [pDATA_WIDTH-1:0] rd_val_p2
);

  logic wr_acc;
  logic rd_acc;
  logic rd_busy;
  logic rd_vld_p2;

  // A write accept blocks a same-cycle read accept so the two never share
  // the tap port in the same cycle.
  assign wr_acc  = awvalid & wvalid & ~wr_vld_p1;
  assign rd_busy = rd_vld_p1 | rd_vld_p2 | rvalid;
  assign rd_acc  = arvalid & ~rd_busy & ~wr_acc;

  assign awready = wr_vld_p1;
  assign wready  = wr_vld_p1;
  assign arready = rd_vld_p1;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
      rd_vld_p2 <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
    end else begin
      wr_vld_p1 <= wr_acc;
      rd_vld_p1 <= rd_acc;
      rd_vld_p2 <= rd_vld_p1;
      if (rd_vld_p2) begin
        rvalid <= 1'b1;
        rdata  <= rd_val_p2;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // p0 -> p1: address/data capture on accept
  always_ff @(posedge axis_clk) begin
    if (wr_acc) begin
      wr_addr_p1 <= awaddr;
      wr_data_p1 <= wdata;
    end
    if (rd_acc) begin
      rd_addr_p1 <= araddr;
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// FIR engine control: ap_ctrl/data_length registers, run sequencing and
// arbitration of the single tap BRAM port between host and engine.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic                   sm_tvalid,
  input  logic                   sm_tready,
  input  logic                   sm_tlast,
  output logic                   eng_start,
  output logic                   eng_tap_gnt,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] data_length,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_DLEN    = pADDR_WIDTH'(ADDR_DLEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP     = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * Tape_Num);
  localparam logic [pDATA_WIDTH-1:0] ONE       = pDATA_WIDTH'(1);

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= A_TAP) && (a < A_TAP_END);
  endfunction

  logic                   wr_vld_p1;
  logic [pADDR_WIDTH-1:0] wr_addr_p1;
  logic [pDATA_WIDTH-1:0] wr_data_p1;
  logic                   rd_vld_p1;
  logic [pADDR_WIDTH-1:0] rd_addr_p1;
  logic [pDATA_WIDTH-1:0] rd_val_p2;
  logic                   rd_host_p2;

  fir_state_e             state;
  fir_state_e             state_nxt;
  logic                   start_go;
  logic                   run_end;
  logic                   sm_hs;
  logic [pDATA_WIDTH-1:0] dlen_q;
  logic [pDATA_WIDTH-1:0] out_cnt;
  logic                   ap_done;
  logic                   eng_start_q;
  logic [pDATA_WIDTH-1:0] ap_ctrl_val;
  logic                   wr_tap;
  logic                   rd_tap;

  fir_axil_slave #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_axil (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .wr_vld_p1  (wr_vld_p1),
    .wr_addr_p1 (wr_addr_p1),
    .wr_data_p1 (wr_data_p1),
    .rd_vld_p1  (rd_vld_p1),
    .rd_addr_p1 (rd_addr_p1),
    .rd_val_p2  (rd_val_p2)
  );

  assign sm_hs = sm_tvalid & sm_tready;

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    run_end   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_vld_p1 && wr_addr_p1 == A_CTRL && wr_data_p1[AP_START_BIT] && dlen_q != '0) begin
          start_go  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (sm_hs && (out_cnt == dlen_q - ONE || sm_tlast)) begin
          run_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      eng_start_q <= 1'b0;
      ap_done     <= 1'b0;
      out_cnt     <= '0;
      dlen_q      <= '0;
    end else begin
      eng_start_q <= start_go;
      if (start_go) begin
        out_cnt <= '0;
      end else if (state == RUN && sm_hs) begin
        out_cnt <= out_cnt + ONE;
      end
      // Completion takes priority over a coincident ap_ctrl read clearing done.
      if (start_go) begin
        ap_done <= 1'b0;
      end else if (run_end) begin
        ap_done <= 1'b1;
      end else if (rvalid && rready && rd_addr_p1 == A_CTRL) begin
        ap_done <= 1'b0;
      end
      if (wr_vld_p1 && wr_addr_p1 == A_DLEN && state == IDLE) begin
        dlen_q <= wr_data_p1;
      end
    end
  end

  assign eng_start   = eng_start_q;
  assign data_length = dlen_q;

  always_comb begin
    ap_ctrl_val               = '0;
    ap_ctrl_val[AP_START_BIT] = eng_start_q;
    ap_ctrl_val[AP_DONE_BIT]  = ap_done;
    ap_ctrl_val[AP_IDLE_BIT]  = (state == IDLE);
  end

  // p1 -> p2: remember whether the host actually owned the tap port when the
  // read address was presented; otherwise tap_Do belongs to the engine.
  always_ff @(posedge axis_clk) begin
    if (rd_vld_p1) begin
      rd_host_p2 <= (state == IDLE);
    end
  end

  always_comb begin
    rd_val_p2 = '0;
    if (is_tap(rd_addr_p1)) begin
      if (rd_host_p2) begin
        rd_val_p2 = tap_Do;
      end
    end else if (rd_addr_p1 == A_CTRL) begin
      rd_val_p2 = ap_ctrl_val;
    end else if (rd_addr_p1 == A_DLEN) begin
      rd_val_p2 = dlen_q;
    end
  end

  assign eng_tap_gnt = (state == RUN);
  assign tap_EN      = 1'b1;
  assign wr_tap      = wr_vld_p1 && is_tap(wr_addr_p1) && (state == IDLE);
  assign rd_tap      = rd_vld_p1 && is_tap(rd_addr_p1);

  always_comb begin
    tap_WE = 4'h0;
    tap_Di = '0;
    tap_A  = '0;
    if (eng_tap_gnt) begin
      tap_A = eng_tap_A;
    end else if (wr_tap) begin
      tap_WE = 4'hF;
      tap_A  = wr_addr_p1 - A_TAP;
      tap_Di = wr_data_p1;
    end else if (rd_tap) begin
      tap_A = rd_addr_p1 - A_TAP;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: behavioural tap BRAM, AXI-Lite host tasks and a
// queue of expected read data popped when rvalid appears.
module tb_fir_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic [AW-1:0] awaddr, araddr, eng_tap_A, tap_A;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, data_length, tap_Di, tap_Do;
  logic          sm_tvalid, sm_tready, sm_tlast, eng_start, eng_tap_gnt, tap_EN;
  logic [3:0]    tap_WE;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] bram[0:31];

  fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wready      (wready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rready      (rready),
    .sm_tvalid   (sm_tvalid),
    .sm_tready   (sm_tready),
    .sm_tlast    (sm_tlast),
    .eng_start   (eng_start),
    .eng_tap_gnt (eng_tap_gnt),
    .eng_tap_A   (eng_tap_A),
    .data_length (data_length),
    .tap_WE      (tap_WE),
    .tap_EN      (tap_EN),
    .tap_Di      (tap_Di),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[6:2]] <= tap_Di;
      tap_Do <= bram[tap_A[6:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] exp_we, input logic [AW-1:0] exp_a,
                            input bit chk_tap, input string tag);
    awaddr  = a;
    wdata   = d;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    chk1({tag, "_awready"}, awready, 1'b1);
    chk1({tag, "_wready"}, wready, 1'b1);
    if (chk_tap) begin
      chk({tag, "_tap_WE"}, 32'(tap_WE), 32'(exp_we));
      chk({tag, "_tap_A"}, 32'(tap_A), 32'(exp_a));
      if (exp_we != 4'h0) chk({tag, "_tap_Di"}, tap_Di, d);
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tick();
    chk1({tag, "_awready_drop"}, awready, 1'b0);
  endtask

  task automatic axil_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    int n;
    exp_q.push_back(exp);
    araddr  = a;
    arvalid = 1'b1;
    tick();
    chk1({tag, "_arready"}, arready, 1'b1);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk1({tag, "_rvalid_clr"}, rvalid, 1'b0);
  endtask

  task automatic sm_beats(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      sm_tvalid = 1'b1;
      sm_tready = 1'b1;
      sm_tlast  = last_on_final && (i == n - 1);
      tick();
    end
    sm_tvalid = 1'b0;
    sm_tready = 1'b0;
    sm_tlast  = 1'b0;
  endtask

  initial begin
    int n;
    axis_rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; eng_tap_A = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
    sm_tvalid = 1'b0; sm_tready = 1'b0; sm_tlast = 1'b0;
    tick();
    tick();

    chk1("rst_awready", awready, 1'b0);
    chk1("rst_wready", wready, 1'b0);
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk1("rst_eng_start", eng_start, 1'b0);
    chk1("rst_gnt", eng_tap_gnt, 1'b0);
    chk("rst_tap_WE", 32'(tap_WE), 32'h0);
    chk1("rst_tap_EN", tap_EN, 1'b1);
    chk("rst_tap_A", 32'(tap_A), 32'h0);
    chk("rst_tap_Di", tap_Di, 32'h0);
    chk("rst_dlen", data_length, 32'h0);
    axis_rst = 1'b0;
    tick();
    axil_read(12'h000, 32'h4, "rst_ap_ctrl");

    // Tap programming and readback in IDLE.
    for (int k = 0; k < 11; k++)
      axil_write(AW'(32'h20 + 4 * k), DW'(k + 1), 4'hF, AW'(4 * k), 1'b1, "tap_wr");
    for (int k = 0; k < 11; k++)
      axil_read(AW'(32'h20 + 4 * k), DW'(k + 1), "tap_rd");
    axil_write(12'h04C, 32'h77, 4'h0, 12'h000, 1'b1, "past_window_wr");
    axil_read(12'h04C, 32'h0, "past_window_rd");
    axil_read(12'h100, 32'h0, "unmapped_rd");

    // First run of five samples.
    axil_write(12'h010, 32'd5, 4'h0, 12'h0, 1'b0, "dlen_wr");
    axil_read(12'h010, 32'd5, "dlen_rd");
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "start1");
    chk1("run1_start_pulse", eng_start, 1'b1);
    chk1("run1_gnt", eng_tap_gnt, 1'b1);
    tick();
    chk1("run1_start_once", eng_start, 1'b0);
    axil_read(12'h000, 32'h0, "run1_ap_ctrl");
    sm_beats(4, 1'b0);
    chk1("run1_gnt_after4", eng_tap_gnt, 1'b1);
    sm_beats(1, 1'b0);
    chk1("run1_gnt_after5", eng_tap_gnt, 1'b0);
    axil_read(12'h000, 32'h6, "run1_done");
    axil_read(12'h000, 32'h4, "run1_done_clr");

    // Host accesses while the engine owns the tap port.
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "start2");
    chk1("run2_start_pulse", eng_start, 1'b1);
    eng_tap_A = 12'h0AC;
    sm_beats(2, 1'b0);
    axil_write(12'h024, 32'hDEAD, 4'h0, 12'h0AC, 1'b1, "run2_tap_wr");
    axil_write(12'h010, 32'd9, 4'h0, 12'h0AC, 1'b1, "run2_dlen_wr");
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "run2_restart");
    chk1("run2_restart_ignored", eng_start, 1'b0);
    axil_read(12'h024, 32'h0, "run2_tap_rd");
    chk("run2_dlen_port", data_length, 32'd5);
    sm_beats(2, 1'b0);
    chk1("run2_gnt_after4", eng_tap_gnt, 1'b1);
    sm_beats(1, 1'b0);
    chk1("run2_gnt_after5", eng_tap_gnt, 1'b0);
    eng_tap_A = 12'h000;
    axil_read(12'h000, 32'h6, "run2_done");
    axil_read(12'h024, 32'd2, "run2_tap_keep");
    axil_read(12'h010, 32'd5, "run2_dlen_keep");

    // Early termination on sm_tlast.
    axil_write(12'h010, 32'd600, 4'h0, 12'h0, 1'b0, "dlen600");
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "start3");
    sm_beats(2, 1'b0);
    sm_tvalid = 1'b1; sm_tready = 1'b0; sm_tlast = 1'b1;
    tick();
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
    chk1("run3_tlast_no_ready", eng_tap_gnt, 1'b1);
    sm_beats(1, 1'b1);
    chk1("run3_gnt_tlast", eng_tap_gnt, 1'b0);
    axil_read(12'h000, 32'h6, "run3_done");

    // Reset in the middle of a run.
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "start4");
    sm_beats(2, 1'b0);
    chk1("run4_gnt", eng_tap_gnt, 1'b1);
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    chk1("midrst_gnt", eng_tap_gnt, 1'b0);
    chk("midrst_dlen", data_length, 32'h0);
    chk1("midrst_start", eng_start, 1'b0);
    axil_read(12'h000, 32'h4, "midrst_ap_ctrl");

    // Start with zero data_length is ignored.
    axil_write(12'h000, 32'h1, 4'h0, 12'h0, 1'b0, "start_zero");
    chk1("zero_no_start", eng_start, 1'b0);
    chk1("zero_no_gnt", eng_tap_gnt, 1'b0);

    // Same-cycle write and read to the same tap.
    awaddr = 12'h028; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h028; arvalid = 1'b1;
    exp_q.push_back(32'h55);
    tick();
    chk1("sim_awready", awready, 1'b1);
    chk1("sim_arready_held", arready, 1'b0);
    chk("sim_tap_WE", 32'(tap_WE), 32'hF);
    chk("sim_tap_A_wr", 32'(tap_A), 32'h008);
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk1("sim_arready", arready, 1'b1);
    chk("sim_tap_A_rd", 32'(tap_A), 32'h008);
    chk("sim_tap_WE_rd", 32'(tap_WE), 32'h0);
    arvalid = 1'b0;
    n = 2;
    while (!rvalid && n < 14) begin
      tick();
      n++;
    end
    chk("sim_latency", 32'(n), 32'd4);
    chk("sim_rdata", rdata, exp_q.pop_front());
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk1("sim_rvalid_clr", rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
- Control, status and tap-BRAM arbitration block for the FIR engine.
- Terminates the AXI-Lite slave and holds the ap_ctrl and data_length registers.
- Sequences one FIR run (start pulse, output counting, done/idle flags).
- Owns the single tap BRAM port: the host gets it while idle, the FIR engine gets it while running.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width (byte addresses).
- pDATA_WIDTH, 32, data width.
- Tape_Num, 11, number of taps; tap window is 0x020 to 0x020+4*Tape_Num-1.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst  in  1  synchronous, active-high reset.
- awaddr  in  pADDR_WIDTH / awvalid  in  1 / awready  out  1  write address channel.
- wdata  in  pDATA_WIDTH / wvalid  in  1 / wready  out  1  write data channel.
- araddr  in  pADDR_WIDTH / arvalid  in  1 / arready  out  1  read address channel.
- rdata  out  pDATA_WIDTH / rvalid  out  1 / rready  in  1  read data channel.
- sm_tvalid, sm_tready, sm_tlast  in  1 each  monitored engine output stream.
- eng_start  out  1  one-cycle run start pulse to the engine.
- eng_tap_gnt  out  1  engine owns the tap port.
- eng_tap_A  in  pADDR_WIDTH  engine tap address.
- data_length  out  pDATA_WIDTH  programmed sample count.
- tap_WE  out  4 / tap_EN  out  1 / tap_Di  out  pDATA_WIDTH / tap_A  out  pADDR_WIDTH / tap_Do  in  pDATA_WIDTH  tap BRAM port.

Behaviour:
- Reset values: awready=wready=arready=rvalid=0, rdata=0, eng_start=0, eng_tap_gnt=0, tap_WE=0, tap_EN=1, tap_A=0, tap_Di=0, data_length=0, state IDLE, ap_idle=1, ap_done=0.
- Register map:
  - 0x000 ap_ctrl. Read returns {29'b0, ap_idle, ap_done, ap_start}. Writing bit0=1 requests start. ap_done is cleared by the rvalid&rready handshake of a 0x000 read.
  - 0x010 data_length, read/write.
  - Tap window: host address 0x020+4k maps to tap_A=4k.
  - All other addresses: reads return 0, writes are dropped.
- Write handshake:
  - awvalid&wvalid both high at cycle t gives awready=wready=1 for exactly cycle t+1; the write commits in t+1.
  - A tap write drives tap_WE=4'hF, tap_A and tap_Di in t+1.
  - awvalid without wvalid is held off (no ready).
- Read handshake:
  - arvalid at t gives arready=1 at t+1; the address is latched and tap_A driven at t+1.
  - tap_Do is captured at t+2.
  - rvalid=1 from t+3 with rdata stable until rready; only one read outstanding.
  - Non-tap reads follow the same timing.
- Simultaneous write and read accepts: the write wins the tap port; the read is accepted one cycle later.
- FSM IDLE -> RUN -> IDLE:
  - IDLE: ap_idle=1. A committed ap_start write with data_length!=0 enters RUN: eng_start=1 for one cycle, ap_start reads 1 for that cycle only, ap_idle=0, ap_done=0, output counter=0.
  - Start with data_length==0 is ignored.
  - Start written while in RUN is ignored.
  - RUN: each sm_tvalid&sm_tready increments the counter. When the handshake occurs with counter==data_length-1, or with sm_tlast=1, go to IDLE next cycle with ap_done=1 and ap_idle=1.
- Arbitration:
  - eng_tap_gnt=1 exactly while in RUN; then tap_A=eng_tap_A and tap_WE=0.
  - Host tap writes in RUN complete the handshake but are dropped.
  - Host tap reads in RUN return 0.
  - data_length writes in RUN are dropped.
- Counter is pDATA_WIDTH wide; no wrap within a legal run.
- Reset mid-run: immediate return to the reset values; the engine sees eng_tap_gnt fall in the same cycle.

Decomposition:
- fir_pkg holds:
  - register offsets (ADDR_AP_CTRL=0x000, ADDR_DLEN=0x010, ADDR_TAP_BASE=0x020);
  - ap_ctrl bit positions;
  - FSM state encodings (IDLE, RUN).
- One sub-module, fir_axil_slave: AXI-Lite handshakes, address latching and read-data return. It outputs decoded write/read strobes to the fir_ctrl top, which holds the registers, FSM and arbiter.

Test Plan:
- Write taps 0..10 = 1..11 at 0x020..0x048 in IDLE, then read them back -> tap_WE=4'hF with tap_A=0x000..0x028; rdata 1..11, each with rvalid at t+3.
- Write data_length=5, write 0x000=1 -> eng_start pulses once, eng_tap_gnt=1, 0x000 reads 0x0; after 5 sm handshakes, 0x000 reads 0x6, and a second read returns 0x4.
- During RUN, write tap 0x024=0xDEAD and data_length=9 -> no tap_WE pulse, tap_A tracks eng_tap_A; after the run, tap readback is unchanged and data_length still reads 5.
- data_length=600 with sm_tlast on handshake 3 -> done after the 3rd handshake, ap_idle=1.
- Assert axis_rst for one cycle mid-RUN -> the next cycle shows eng_tap_gnt=0, data_length=0, and 0x000 reads 0x4.
- Same-cycle awvalid/wvalid/arvalid to tap addresses -> the write commits first, arready follows one cycle later, and rdata returns the newly written value.
